// File: rtl/ghost_mover.sv
// Sprite mover: steps a sprite origin once every FRAME_DIV frames, clamping and bouncing at the screen edges.
// Optional macro GHOST_WANDER_EN: bounces turn 90 degrees, picked by an 8-bit LFSR.
module ghost_mover #(
  parameter int H_MAX     = 640,
  parameter int V_MAX     = 480,
  parameter int SPRITE    = 16,
  parameter int FRAME_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        run,
  input  logic        wr,
  input  logic [1:0]  wr_addr,
  input  logic [15:0] wr_data,
  output logic [10:0] x0,
  output logic [10:0] y0,
  output logic [3:0]  ctrl,
  output logic        moving
);

  localparam logic [11:0] XMAX     = 12'(H_MAX - SPRITE);
  localparam logic [11:0] YMAX     = 12'(V_MAX - SPRITE);
  localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);

  typedef enum logic [1:0] {STOP, WAIT, MOVE} state_t;

  state_t      state;
  logic [7:0]  frame_cnt;
  logic [3:0]  speed;

  // Returns {bounce, new_pos}; a hit on either limit clamps and flags a bounce.
  function automatic logic [12:0] step_pos(input logic [11:0] pos, input logic [3:0] spd,
                                           input logic dec, input logic [11:0] lim);
    logic [11:0] spd_w;
    logic [11:0] sum;
    logic [12:0] res;
    spd_w = {8'd0, spd};
    sum   = pos + spd_w;
    if (dec) begin
      if (pos <= spd_w) res = {1'b1, 12'd0};
      else              res = {1'b0, pos - spd_w};
    end else begin
      if (sum >= lim)   res = {1'b1, lim};
      else              res = {1'b0, sum};
    end
    return res;
  endfunction

  function automatic logic [10:0] clamp_load(input logic [10:0] val, input logic [11:0] lim);
    logic [10:0] res;
    if ({1'b0, val} > lim) res = lim[10:0];
    else                   res = val;
    return res;
  endfunction

  logic [1:0]  dir;
  logic        vert;
  logic        dec;
  logic [12:0] step_r;
  logic        bounce;
  logic [1:0]  new_dir;
  logic        do_step;

  assign dir  = ctrl[1:0];
  assign vert = dir[1];
  // Screen y grows downwards, so "up" (10) decrements and "left" (01) decrements.
  assign dec  = dir[1] ^ dir[0];
  assign step_r = step_pos(vert ? {1'b0, y0} : {1'b0, x0}, speed, dec, vert ? YMAX : XMAX);
  assign bounce = step_r[12];

  // A write landing in the MOVE cycle takes priority and the whole step is discarded.
  assign do_step = (state == MOVE) && run && !wr && (speed != 4'd0);

`ifdef GHOST_WANDER_EN
  logic [7:0] lfsr;
  logic       lfsr_fb;
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign new_dir = !bounce ? dir : (vert ? {1'b0, lfsr[0]} : {1'b1, lfsr[0]});

  always_ff @(posedge clk) begin
    if (reset)              lfsr <= 8'h01;
    else if (state == MOVE) lfsr <= {lfsr[6:0], lfsr_fb};
  end
`else
  assign new_dir = bounce ? (dir ^ 2'b01) : dir;
`endif

  logic unused_bits;
  assign unused_bits = ^{wr_data[15:11], step_r[11]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= STOP;
      frame_cnt <= 8'd0;
      moving    <= 1'b0;
      x0        <= 11'd0;
      y0        <= 11'd0;
      ctrl      <= 4'd0;
      speed     <= 4'd1;
    end else begin
      if (!run) begin
        state     <= STOP;
        frame_cnt <= 8'd0;
        moving    <= 1'b0;
      end else begin
        case (state)
          STOP: begin
            state  <= WAIT;
            moving <= 1'b1;
          end
          WAIT: begin
            if (frame_start) begin
              if (frame_cnt == DIV_LAST) begin
                frame_cnt <= 8'd0;
                state     <= MOVE;
              end else begin
                frame_cnt <= frame_cnt + 8'd1;
              end
            end
          end
          MOVE:    state <= WAIT;
          default: state <= STOP;
        endcase
      end

      if (wr) begin
        case (wr_addr)
          2'd0: x0    <= clamp_load(wr_data[10:0], XMAX);
          2'd1: y0    <= clamp_load(wr_data[10:0], YMAX);
          2'd2: speed <= wr_data[3:0];
          2'd3: ctrl  <= wr_data[3:0];
          default: ;
        endcase
      end else if (do_step) begin
        if (vert) y0 <= step_r[10:0];
        else      x0 <= step_r[10:0];
        ctrl[1:0] <= new_dir;
      end
    end
  end

endmodule

// File: tb/tb_ghost_mover.sv
// Directed bench for ghost_mover: FRAME_DIV=1 instance plus a FRAME_DIV=3 instance on shared inputs.
module tb_ghost_mover;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        run;
  logic        wr;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;

  logic [10:0] x0, y0, x3, y3;
  logic [3:0]  ctrl, ctrl3;
  logic        moving, moving3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ghost_mover #(.FRAME_DIV(1)) u_dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .run(run),
    .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
    .x0(x0), .y0(y0), .ctrl(ctrl), .moving(moving)
  );

  ghost_mover #(.FRAME_DIV(3)) u_div3 (
    .clk(clk), .reset(reset), .frame_start(frame_start), .run(run),
    .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
    .x0(x3), .y0(y3), .ctrl(ctrl3), .moving(moving3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [1:0] addr, input logic [15:0] data);
    wr = 1'b1; wr_addr = addr; wr_data = data;
    tick();
    wr = 1'b0;
  endtask

  task automatic do_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; run = 1'b0; wr = 1'b0; wr_addr = 2'd0; wr_data = 16'd0;
    tick(); tick();
    reset = 1'b0;
    check("reset_x0", x0, 0);
    check("reset_y0", y0, 0);
    check("reset_ctrl", ctrl, 0);
    check("reset_moving", moving, 0);

    // Basic stepping at speed 1
    run = 1'b1;
    tick();
    check("moving_on", moving, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("latency_x0_early", x0, 0);
    tick();
    check("step1_x0", x0, 1);
    do_frame();
    check("step2_x0", x0, 2);
    do_frame();
    check("step3_x0", x0, 3);
    check("step3_y0", y0, 0);
    check("step3_ctrl", ctrl, 0);

    // Right edge clamp and bounce
    do_write(2'd0, 16'd620);
    check("wr_x620", x0, 620);
    do_write(2'd2, 16'd5);
    do_write(2'd3, 16'd0);
    do_frame();
    check("right_clamp_x0", x0, 624);
    check("right_bounce_dir", ctrl[1:0], 2'b01);
    do_frame();
    check("left_step_x0", x0, 619);

    // Top edge clamp and bounce
    do_write(2'd1, 16'd3);
    do_write(2'd3, 16'd2);
    do_write(2'd2, 16'd7);
    do_frame();
    check("up_clamp_y0", y0, 0);
    check("up_bounce_ctrl", ctrl, 4'b0011);
    check("up_x0_kept", x0, 619);
    do_frame();
    check("down_step_y0", y0, 7);

    // Colour field and left step
    do_write(2'd3, 16'd13);
    check("colour_ctrl", ctrl, 4'b1101);
    do_frame();
    check("left7_x0", x0, 612);
    check("left7_ctrl", ctrl, 4'b1101);

    // frame_start still high in MOVE must not start another step
    frame_start = 1'b1;
    tick(); tick();
    frame_start = 1'b0;
    tick();
    check("frame_in_move_x0", x0, 605);

    // Write during MOVE wins
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    do_write(2'd0, 16'd100);
    check("move_write_x0", x0, 100);
    check("move_write_ctrl", ctrl, 4'b1101);
    tick();
    check("move_write_hold_x0", x0, 100);

    do_write(2'd0, 16'd2000);
    check("clamp_x2000", x0, 624);
    do_write(2'd1, 16'd2000);
    check("clamp_y2000", y0, 464);

    // Speed zero leaves everything unchanged
    do_write(2'd2, 16'd0);
    do_frame();
    check("speed0_x0", x0, 624);
    check("speed0_ctrl", ctrl, 4'b1101);

    // Stop freezes
    do_write(2'd2, 16'd3);
    run = 1'b0;
    tick();
    check("stop_moving", moving, 0);
    do_frame();
    check("stop_x0", x0, 624);

    // Reset beats a concurrent write
    reset = 1'b1; wr = 1'b1; wr_addr = 2'd0; wr_data = 16'd50;
    tick();
    reset = 1'b0; wr = 1'b0;
    check("reset_vs_write_x0", x0, 0);
    check("reset_vs_write_x3", x3, 0);

    // FRAME_DIV=3 instance
    run = 1'b1;
    tick();
    do_write(2'd2, 16'd2);
    do_frame();
    check("div3_f1", x3, 0);
    do_frame();
    check("div3_f2", x3, 0);
    do_frame();
    check("div3_f3", x3, 2);
    do_frame();
    do_frame();
    check("div3_f5", x3, 2);
    run = 1'b0;
    tick();
    check("div3_stop_moving", moving3, 0);
    run = 1'b1;
    tick();
    do_frame();
    do_frame();
    check("div3_resume_f2", x3, 2);
    do_frame();
    check("div3_resume_f3", x3, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
